// File: rtl/particle_streamer.sv
// rtl/particle_streamer.sv - walks particle BRAM once per frame and hands each position to the projector.
// Optional build macro PARTICLE_CULL_BEHIND_EN drops particles whose f_z sign bit is set.
`timescale 1ns/1ps
module particle_streamer #(
    parameter int NUM_PARTICLES = 64,
    parameter int ADDR_WIDTH    = (NUM_PARTICLES > 1) ? $clog2(NUM_PARTICLES) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [47:0]           mem_data_in,
    input  logic                  projector_ready_in,
    output logic [15:0]           f_x_out,
    output logic [15:0]           f_y_out,
    output logic [15:0]           f_z_out,
    output logic                  data_valid_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_WAIT    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t                state_q;
    logic                  wait_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           f_x_q;
    logic [15:0]           f_y_q;
    logic [15:0]           f_z_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic cull_d;
    logic last_d;
    logic advance_d;

`ifdef PARTICLE_CULL_BEHIND_EN
    assign cull_d = mem_data_in[15];
`else
    assign cull_d = 1'b0;
`endif

    assign last_d = (addr_q == ADDR_WIDTH'(NUM_PARTICLES - 1));

    // A culled slot sits in PRESENT with valid low and advances unconditionally.
    assign advance_d = valid_q ? projector_ready_in : 1'b1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 1'b0;
            addr_q     <= '0;
            f_x_q      <= '0;
            f_y_q      <= '0;
            f_z_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A pulse landing on the done cycle is dropped, not deferred.
                    if (frame_start_in && !done_q) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                S_FETCH: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= 1'b0;
                end
                S_WAIT: begin
                    if (wait_cnt_q) begin
                        state_q <= S_PRESENT;
                        if (!cull_d) begin
                            f_x_q   <= mem_data_in[47:32];
                            f_y_q   <= mem_data_in[31:16];
                            f_z_q   <= mem_data_in[15:0];
                            valid_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (advance_d) begin
                        valid_q <= 1'b0;
                        if (last_d) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            addr_q  <= '0;
                        end else begin
                            state_q <= S_FETCH;
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr_out   = addr_q;
    assign f_x_out        = f_x_q;
    assign f_y_out        = f_y_q;
    assign f_z_out        = f_z_q;
    assign data_valid_out = valid_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_particle_streamer.sv
// tb/tb_particle_streamer.sv - directed bench for particle_streamer (4-particle and 1-particle instances).
`timescale 1ns/1ps
module tb_particle_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        fs = 1'b0, rdy = 1'b1;
    logic [1:0]  addr;
    logic [47:0] s1, s2;
    logic [15:0] fx, fy, fz;
    logic        valid, busy, done;

    logic        fs1 = 1'b0;
    logic [0:0]  addr1;
    logic [47:0] t1, t2;
    logic [15:0] fx1, fy1, fz1;
    logic        valid1, busy1, done1;

    logic [47:0] mem [0:3];

    int          xfer_cyc[$];
    logic [47:0] xfer_dat[$];
    int          done_cyc[$];
    logic        done_busy[$];
    logic [1:0]  done_addr[$];
    int          xfer1_cyc[$];
    int          done1_cyc[$];
    logic        done1_busy[$];
    logic        addr_bad = 1'b0;
    logic        p1_seen = 1'b0;

    particle_streamer #(.NUM_PARTICLES(4)) u_dut (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs), .mem_addr_out(addr),
        .mem_data_in(s2), .projector_ready_in(rdy),
        .f_x_out(fx), .f_y_out(fy), .f_z_out(fz),
        .data_valid_out(valid), .busy_out(busy), .frame_done_out(done)
    );

    particle_streamer #(.NUM_PARTICLES(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs1), .mem_addr_out(addr1),
        .mem_data_in(t2), .projector_ready_in(1'b1),
        .f_x_out(fx1), .f_y_out(fy1), .f_z_out(fz1),
        .data_valid_out(valid1), .busy_out(busy1), .frame_done_out(done1)
    );

    always #5 clk = ~clk;

    // Two-stage BRAM read pipeline.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        s1  <= mem[addr];
        s2  <= s1;
        t1  <= mem[{1'b0, addr1}];
        t2  <= t1;
    end

    always @(negedge clk) begin
        if (valid && rdy) begin
            xfer_cyc.push_back(cyc);
            xfer_dat.push_back({fx, fy, fz});
        end
        if (valid && fx == 16'h3C01) p1_seen = 1'b1;
        if (done) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy);
            done_addr.push_back(addr);
        end
        if (addr > 2'd3) addr_bad = 1'b1;
        if (valid1) xfer1_cyc.push_back(cyc);
        if (done1) begin
            done1_cyc.push_back(cyc);
            done1_busy.push_back(busy1);
        end
    end

    function automatic logic [47:0] word(input int k);
        return {16'h3C00 + 16'(k), 16'h4000 + 16'(k), 16'h4200 + 16'(k)};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse(output int t);
        tick();
        fs = 1'b1;
        t  = cyc;
        tick();
        fs = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        tick();
        check_eq("done_seen", 64'(done_cyc.size() > 0), 64'd1);
    endtask

    task automatic clear();
        xfer_cyc.delete(); xfer_dat.delete();
        done_cyc.delete(); done_busy.delete(); done_addr.delete();
    endtask

    initial begin
        int t0;
        int c1;
        int n;
        logic stable;
        for (int k = 0; k < 4; k++) mem[k] = word(k);

        // Reset state
        repeat (2) tick();
        check_eq("rst_addr", 64'(addr), 64'd0);
        check_eq("rst_data", 64'({fx, fy, fz}), 64'd0);
        check_eq("rst_flags", 64'({valid, busy, done}), 64'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Basic frame at full throughput
        clear();
        rdy = 1'b1;
        pulse(t0);
        check_eq("a_busy_t1", 64'(busy), 64'd1);
        check_eq("a_addr_t1", 64'(addr), 64'd0);
        wait_done(40);
        check_eq("a_nxfer", 64'(xfer_cyc.size()), 64'd4);
        for (int k = 0; k < 4 && k < xfer_cyc.size(); k++) begin
            check_eq($sformatf("a_cyc%0d", k), 64'(xfer_cyc[k] - t0), 64'(4 + 4 * k));
            check_eq($sformatf("a_dat%0d", k), 64'(xfer_dat[k]), 64'(word(k)));
        end
        if (done_cyc.size() > 0) begin
            check_eq("a_done_cyc", 64'(done_cyc[0] - t0), 64'd17);
            check_eq("a_done_busy", 64'(done_busy[0]), 64'd0);
            check_eq("a_done_addr", 64'(done_addr[0]), 64'd0);
        end
        check_eq("a_ndone", 64'(done_cyc.size()), 64'd1);

        // Backpressure: ready low for 10 valid cycles
        clear();
        rdy = 1'b0;
        pulse(t0);
        n = 0;
        while (!valid && n < 20) begin tick(); n++; end
        check_eq("b_valid_seen", 64'(valid), 64'd1);
        check_eq("b_first_cyc", 64'(cyc - t0), 64'd4);
        stable = 1'b1;
        repeat (10) begin
            if (!(valid && {fx, fy, fz} == word(0))) stable = 1'b0;
            tick();
        end
        check_eq("b_stable", 64'(stable), 64'd1);
        rdy = 1'b1;
        c1  = cyc;
        wait_done(40);
        check_eq("b_nxfer", 64'(xfer_cyc.size()), 64'd4);
        if (xfer_cyc.size() > 0) check_eq("b_xfer0_cyc", 64'(xfer_cyc[0]), 64'(c1));
        check_eq("b_ndone", 64'(done_cyc.size()), 64'd1);

        // Restart pulses while busy and on the done cycle are ignored
        clear();
        pulse(t0);
        goto(t0 + 6);
        fs = 1'b1; tick(); fs = 1'b0;
        goto(t0 + 17);
        fs = 1'b1; tick(); fs = 1'b0;
        tick();
        check_eq("c_busy_after", 64'(busy), 64'd0);
        repeat (6) tick();
        check_eq("c_nxfer", 64'(xfer_cyc.size()), 64'd4);
        check_eq("c_ndone", 64'(done_cyc.size()), 64'd1);

        // Asynchronous reset mid-frame
        clear();
        pulse(t0);
        goto(t0 + 9);
        rst = 1'b0;
        #1;
        check_eq("d_rst_addr", 64'(addr), 64'd0);
        check_eq("d_rst_data", 64'({fx, fy, fz}), 64'd0);
        check_eq("d_rst_flags", 64'({valid, busy, done}), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) tick();
        check_eq("d_no_done", 64'(done_cyc.size()), 64'd0);
        check_eq("d_idle", 64'(busy), 64'd0);
        clear();
        pulse(t0);
        wait_done(40);
        if (xfer_cyc.size() > 0) begin
            check_eq("d_restart_cyc", 64'(xfer_cyc[0] - t0), 64'd4);
            check_eq("d_restart_dat", 64'(xfer_dat[0]), 64'(word(0)));
        end
        check_eq("d_nxfer", 64'(xfer_cyc.size()), 64'd4);

        // Particle 1 behind the camera
        clear();
        p1_seen = 1'b0;
        mem[1] = {16'h3C01, 16'h4001, 16'hC200};
        pulse(t0);
        wait_done(40);
`ifdef PARTICLE_CULL_BEHIND_EN
        check_eq("e_nxfer", 64'(xfer_cyc.size()), 64'd3);
        check_eq("e_p1_seen", 64'(p1_seen), 64'd0);
        if (xfer_cyc.size() == 3) begin
            check_eq("e_dat0", 64'(xfer_dat[0]), 64'(word(0)));
            check_eq("e_dat1", 64'(xfer_dat[1]), 64'(word(2)));
            check_eq("e_dat2", 64'(xfer_dat[2]), 64'(word(3)));
            check_eq("e_cyc2", 64'(xfer_cyc[1] - t0), 64'd12);
        end
`else
        check_eq("e_nxfer", 64'(xfer_cyc.size()), 64'd4);
        if (xfer_cyc.size() == 4)
            check_eq("e_dat1", 64'(xfer_dat[1]), 64'({16'h3C01, 16'h4001, 16'hC200}));
`endif
        if (done_cyc.size() > 0) check_eq("e_done_cyc", 64'(done_cyc[0] - t0), 64'd17);
        check_eq("e_ndone", 64'(done_cyc.size()), 64'd1);
        mem[1] = word(1);

        // Single-particle instance
        tick();
        fs1 = 1'b1;
        t0  = cyc;
        tick();
        fs1 = 1'b0;
        repeat (10) tick();
        check_eq("f_nxfer", 64'(xfer1_cyc.size()), 64'd1);
        if (xfer1_cyc.size() > 0) check_eq("f_xfer_cyc", 64'(xfer1_cyc[0] - t0), 64'd4);
        check_eq("f_ndone", 64'(done1_cyc.size()), 64'd1);
        if (done1_cyc.size() > 0) begin
            check_eq("f_done_cyc", 64'(done1_cyc[0] - t0), 64'd5);
            check_eq("f_done_busy", 64'(done1_busy[0]), 64'd0);
        end
        check_eq("f_data", 64'({fx1, fy1, fz1}), 64'(word(0)));

        check_eq("addr_range", 64'(addr_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
